// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_if
// Brief    : Bundle of the fetch unit's redirect, instruction-memory and
//            decode-side handshake signals.
//            master : the fetch unit itself
//            slave  : the environment (memory, decode, branch unit)
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        misalign;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, misalign
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, misalign
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : Single-outstanding instruction fetch unit. Issues one memory
//            request, waits for its response, offers it to decode, then
//            advances the PC by 4. Redirects replace the fetch PC and squash
//            any old-path response or held instruction.
//            Optional feature macro: INST_FETCH_MISALIGN_CHK_EN
//              defined   : misaligned redirect targets park the unit in FAULT
//              undefined : redirect_pc[1:0] is forced to zero, misalign is 0
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_fetch_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      r_state;
  logic [63:0] r_fetch_pc;
  logic [63:0] r_inst_pc;
  logic [31:0] r_inst;
  logic        r_drop;
  logic        r_req_valid;
  logic        r_inst_valid;
  logic        r_misalign;

  logic [63:0] w_redir_pc;
  logic        w_redir_bad;
  logic        w_redir_ok;
  logic        w_req_fire;

`ifdef INST_FETCH_MISALIGN_CHK_EN
  assign w_redir_pc  = bus.redirect_pc;
  assign w_redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
  // Low bits are masked rather than dropped so the full target stays read.
  assign w_redir_pc  = {bus.redirect_pc[63:2], bus.redirect_pc[1:0] & 2'b00};
  assign w_redir_bad = 1'b0;
`endif

  assign w_redir_ok = bus.redirect_valid && !w_redir_bad;
  assign w_req_fire = r_req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = r_inst_valid;
  assign bus.inst           = r_inst;
  assign bus.inst_pc        = r_inst_pc;
  // Only ever set through the FAULT path, so it stays 0 without the check.
  assign bus.misalign       = r_misalign;

  // Fetch FSM with registered request/instruction outputs and squash tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_fetch_pc   <= RESET_PC;
      r_drop       <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'h0;
      r_inst_pc    <= RESET_PC;
      r_misalign   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_redir_bad) begin
            r_state    <= FAULT;
            r_misalign <= 1'b1;
          end else begin
            if (w_redir_ok) r_fetch_pc <= w_redir_pc;
            r_state     <= REQ;
            r_req_valid <= 1'b1;
          end
        end

        REQ: begin
          if (w_redir_bad) begin
            // An accepted request still owes a response; remember to eat it.
            r_state     <= FAULT;
            r_misalign  <= 1'b1;
            r_req_valid <= 1'b0;
            r_drop      <= w_req_fire;
          end else if (w_req_fire) begin
            r_state     <= WAIT;
            r_req_valid <= 1'b0;
            if (w_redir_ok) begin
              r_fetch_pc <= w_redir_pc;
              r_drop     <= 1'b1;
            end
          end else if (w_redir_ok) begin
            r_fetch_pc <= w_redir_pc;
          end
        end

        WAIT: begin
          if (w_redir_bad) begin
            r_state    <= FAULT;
            r_misalign <= 1'b1;
            r_drop     <= !bus.imem_rsp_valid;
          end else if (w_redir_ok) begin
            r_fetch_pc <= w_redir_pc;
            if (bus.imem_rsp_valid) begin
              r_drop      <= 1'b0;
              r_state     <= REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_drop <= 1'b1;
            end
          end else if (bus.imem_rsp_valid) begin
            if (r_drop) begin
              r_drop      <= 1'b0;
              r_state     <= REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_inst       <= bus.imem_rsp_data;
              r_inst_pc    <= r_fetch_pc;
              r_inst_valid <= 1'b1;
              r_state      <= HOLD;
            end
          end
        end

        HOLD: begin
          if (w_redir_bad) begin
            r_state      <= FAULT;
            r_misalign   <= 1'b1;
            r_inst_valid <= 1'b0;
          end else if (w_redir_ok) begin
            r_inst_valid <= 1'b0;
            r_fetch_pc   <= w_redir_pc;
            r_state      <= REQ;
            r_req_valid  <= 1'b1;
          end else if (bus.inst_ready) begin
            r_inst_valid <= 1'b0;
            r_fetch_pc   <= r_fetch_pc + 64'd4;
            r_state      <= REQ;
            r_req_valid  <= 1'b1;
          end
        end

        FAULT: begin
          if (w_redir_ok) begin
            r_misalign <= 1'b0;
            r_fetch_pc <= w_redir_pc;
            // A response still in flight must be drained before a new request
            // so that only one is ever outstanding.
            if (r_drop && !bus.imem_rsp_valid) begin
              r_state <= WAIT;
            end else begin
              r_drop      <= 1'b0;
              r_state     <= REQ;
              r_req_valid <= 1'b1;
            end
          end else if (bus.imem_rsp_valid) begin
            r_drop <= 1'b0;
          end
        end

        default: begin
          r_state      <= IDLE;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Directed self-checking bench for inst_fetch with a small
//            instruction-memory responder of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          tests     = 0;
  int          fails     = 0;
  int          mem_delay = 1;
  int          req_count = 0;
  int          mem_cnt   = 0;
  logic        mem_pend  = 1'b0;
  logic [63:0] mem_addr  = 64'h0;

  function automatic logic [31:0] dfun(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: one response, mem_delay cycles after acceptance.
  always @(posedge clk) begin
    bus.imem_rsp_valid <= 1'b0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        bus.imem_rsp_valid <= 1'b1;
        bus.imem_rsp_data  <= dfun(mem_addr);
        mem_pend           <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      req_count <= req_count + 1;
      if (mem_delay <= 1) begin
        bus.imem_rsp_valid <= 1'b1;
        bus.imem_rsp_data  <= dfun(bus.imem_req_addr);
      end else begin
        mem_pend <= 1'b1;
        mem_addr <= bus.imem_req_addr;
        mem_cnt  <= mem_delay - 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_inst(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.inst_valid !== 1'b1 && n < 30);
    chk({tag, " inst_valid"}, {63'd0, bus.inst_valid}, 64'd1);
  endtask

  task automatic wait_req(input string tag, output int n);
    logic seen_inst;
    seen_inst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (bus.inst_valid === 1'b1) seen_inst = 1'b1;
    end while (bus.imem_req_valid !== 1'b1 && n < 30);
    chk({tag, " req_valid"}, {63'd0, bus.imem_req_valid}, 64'd1);
    chk({tag, " no inst"}, {63'd0, seen_inst}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rc;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;

    // Reset values
    repeat (3) tick();
    chk("rst req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("rst req_addr",  bus.imem_req_addr, 64'h8000_0000);
    chk("rst inst_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("rst inst", {32'd0, bus.inst}, 64'd0);
    chk("rst inst_pc", bus.inst_pc, 64'h8000_0000);
    chk("rst misalign", {63'd0, bus.misalign}, 64'd0);

    // Release: request visible after 1st edge, accepted on 2nd
    rst_n = 1'b1;
    chk("rel req_valid low", {63'd0, bus.imem_req_valid}, 64'd0);
    tick();
    chk("first req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("first req_addr", bus.imem_req_addr, 64'h8000_0000);

    // Sequential stream, 3 cycles per instruction
    wait_inst("seq0", n);
    chk("seq0 lat", 64'(n), 64'd2);
    chk("seq0 pc", bus.inst_pc, 64'h8000_0000);
    chk("seq0 inst", {32'd0, bus.inst}, {32'd0, dfun(64'h8000_0000)});
    wait_inst("seq1", n);
    chk("seq1 period", 64'(n), 64'd3);
    chk("seq1 pc", bus.inst_pc, 64'h8000_0004);
    wait_inst("seq2", n);
    chk("seq2 period", 64'(n), 64'd3);
    chk("seq2 pc", bus.inst_pc, 64'h8000_0008);

    // Decode stall for 5 cycles
    tick();
    bus.inst_ready = 1'b0;
    wait_inst("stall", n);
    chk("stall pc", bus.inst_pc, 64'h8000_000C);
    rc = req_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall valid", {63'd0, bus.inst_valid}, 64'd1);
      chk("stall pc hold", bus.inst_pc, 64'h8000_000C);
      chk("stall inst hold", {32'd0, bus.inst}, {32'd0, dfun(64'h8000_000C)});
      chk("stall no req", {63'd0, bus.imem_req_valid}, 64'd0);
    end
    chk("stall req count", 64'(req_count), 64'(rc));
    bus.inst_ready = 1'b1;
    tick();
    chk("post stall req", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("post stall addr", bus.imem_req_addr, 64'h8000_0010);

    // Redirect in WAIT before the response arrives
    mem_delay = 3;
    tick();
    chk("wait state", {63'd0, bus.imem_req_valid}, 64'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1000;
    tick();
    bus.redirect_valid = 1'b0;
    wait_req("wait redir", n);
    chk("wait redir addr", bus.imem_req_addr, 64'h8000_1000);
    mem_delay = 1;
    wait_inst("wait redir inst", n);
    chk("wait redir pc", bus.inst_pc, 64'h8000_1000);
    chk("wait redir data", {32'd0, bus.inst}, {32'd0, dfun(64'h8000_1000)});

    // Redirect in HOLD together with inst_ready
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0200;
    tick();
    bus.redirect_valid = 1'b0;
    chk("hold redir inst_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("hold redir req", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("hold redir addr", bus.imem_req_addr, 64'h8000_0200);
    wait_inst("hold redir inst", n);
    chk("hold redir pc", bus.inst_pc, 64'h8000_0200);

    // Redirect in WAIT in the same cycle as the response
    tick();
    chk("seq addr 204", bus.imem_req_addr, 64'h8000_0204);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_2000;
    tick();
    bus.redirect_valid = 1'b0;
    chk("rsp redir req", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("rsp redir addr", bus.imem_req_addr, 64'h8000_2000);
    chk("rsp redir no inst", {63'd0, bus.inst_valid}, 64'd0);
    wait_inst("rsp redir inst", n);
    chk("rsp redir pc", bus.inst_pc, 64'h8000_2000);

    // Redirect in REQ without handshake
    tick();
    bus.imem_req_ready = 1'b0;
    chk("req addr 2004", bus.imem_req_addr, 64'h8000_2004);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_3000;
    tick();
    bus.redirect_valid = 1'b0;
    chk("req redir valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("req redir addr", bus.imem_req_addr, 64'h8000_3000);
    bus.imem_req_ready = 1'b1;
    wait_inst("req redir inst", n);
    chk("req redir pc", bus.inst_pc, 64'h8000_3000);

    // Redirect in REQ with handshake in the same cycle
    tick();
    chk("req addr 3004", bus.imem_req_addr, 64'h8000_3004);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_4000;
    tick();
    bus.redirect_valid = 1'b0;
    chk("hs redir wait", {63'd0, bus.imem_req_valid}, 64'd0);
    wait_req("hs redir", n);
    chk("hs redir addr", bus.imem_req_addr, 64'h8000_4000);
    wait_inst("hs redir inst", n);
    chk("hs redir pc", bus.inst_pc, 64'h8000_4000);

    tick();
    bus.imem_req_ready = 1'b0;
`ifdef INST_FETCH_MISALIGN_CHK_EN
    // Misaligned redirect parks the unit; aligned redirect recovers
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0002;
    tick();
    bus.redirect_valid = 1'b0;
    chk("fault misalign", {63'd0, bus.misalign}, 64'd1);
    chk("fault no req", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("fault no inst", {63'd0, bus.inst_valid}, 64'd0);
    bus.imem_req_ready = 1'b1;
    rc = req_count;
    repeat (3) tick();
    chk("fault stays", {63'd0, bus.misalign}, 64'd1);
    chk("fault still no req", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("fault req count", 64'(req_count), 64'(rc));
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0010;
    tick();
    bus.redirect_valid = 1'b0;
    chk("fault exit misalign", {63'd0, bus.misalign}, 64'd0);
    chk("fault exit req", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("fault exit addr", bus.imem_req_addr, 64'h8000_0010);
    wait_inst("fault exit inst", n);
    chk("fault exit pc", bus.inst_pc, 64'h8000_0010);
`else
    // Low target bits are ignored without the alignment check
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_5002;
    tick();
    bus.redirect_valid = 1'b0;
    chk("mask misalign", {63'd0, bus.misalign}, 64'd0);
    chk("mask req", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("mask addr", bus.imem_req_addr, 64'h8000_5000);
    bus.imem_req_ready = 1'b1;
    wait_inst("mask inst", n);
    chk("mask pc", bus.inst_pc, 64'h8000_5000);
`endif

    // PC wrap-around
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wrap addr top", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_inst("wrap inst", n);
    chk("wrap pc top", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap req", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("wrap addr zero", bus.imem_req_addr, 64'h0);
    wait_inst("wrap inst0", n);
    chk("wrap pc zero", bus.inst_pc, 64'h0);
    chk("wrap data zero", {32'd0, bus.inst}, {32'd0, dfun(64'h0)});

    // Reset in WAIT; the stale response must be ignored
    tick();
    mem_delay = 3;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid rst req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("mid rst addr", bus.imem_req_addr, 64'h8000_0000);
    chk("mid rst inst_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("mid rst inst_pc", bus.inst_pc, 64'h8000_0000);
    tick();
    rst_n = 1'b1;
    wait_inst("after rst inst", n);
    chk("after rst pc", bus.inst_pc, 64'h8000_0000);
    chk("after rst data", {32'd0, bus.inst}, {32'd0, dfun(64'h8000_0000)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
